// File: rtl/frag_mem_pkg.sv
// Shared types and TileLink-UH helpers for frag_mem_arbiter.
// Opcode constants, beat math and the tracking FIFO entry layout.
package frag_mem_pkg;

    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_GET         = 3'd4;
    localparam logic [2:0] TL_D_ACK         = 3'd0;
    localparam logic [2:0] TL_D_ACK_DATA    = 3'd1;

    // Index field is wide enough for the largest supported requester count (8).
    localparam int IDX_W  = 3;
    // Longest burst is 4 beats (size 4 on a 32-bit bus).
    localparam int BEAT_W = 3;
    localparam logic [3:0] MAX_SIZE = 4'd4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [BEAT_W-1:0] beats;
    } track_entry_t;

    function automatic logic size_illegal(input logic [3:0] size);
        return size > MAX_SIZE;
    endfunction

    // opcode is always the A opcode; is_a selects request or response beats.
    function automatic logic [BEAT_W-1:0] beats_from_size(
        input logic [2:0] opcode,
        input logic [3:0] size,
        input logic       is_a
    );
        logic is_put;
        logic multi;
        is_put = (opcode == TL_A_PUT_FULL) || (opcode == TL_A_PUT_PARTIAL);
        multi  = is_a ? is_put : (opcode == TL_A_GET);
        if (!multi || size <= 4'd2 || size_illegal(size)) begin
            return BEAT_W'(1);
        end else if (size == 4'd3) begin
            return BEAT_W'(2);
        end else begin
            return BEAT_W'(4);
        end
    endfunction

endpackage

// File: rtl/frag_mem_track_fifo.sv
// In-order tracking FIFO of outstanding transactions.
// A pop and a push may share a cycle even when full.
module frag_mem_track_fifo
    import frag_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  track_entry_t push_data,
    input  logic         pop,
    output track_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    track_entry_t     slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = slots[rd_ptr];

    // pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // entry storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/frag_mem_arbiter.sv
// Round-robin TL-UH arbiter sharing one memory port among NUM_REQ masters.
// Grants are held for whole Put bursts; D beats follow the in-order FIFO head.
module frag_mem_arbiter
    import frag_mem_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*NUM_REQ-1:0]    req_a_opcode,
    input  logic [3*NUM_REQ-1:0]    req_a_param,
    input  logic [4*NUM_REQ-1:0]    req_a_size,
    input  logic [32*NUM_REQ-1:0]   req_a_address,
    input  logic [4*NUM_REQ-1:0]    req_a_mask,
    input  logic [32*NUM_REQ-1:0]   req_a_data,
    input  logic [NUM_REQ-1:0]      req_a_corrupt,
    input  logic [NUM_REQ-1:0]      req_a_valid,
    output logic [NUM_REQ-1:0]      req_a_ready,
    output logic [3*NUM_REQ-1:0]    req_d_opcode,
    output logic [2*NUM_REQ-1:0]    req_d_param,
    output logic [4*NUM_REQ-1:0]    req_d_size,
    output logic [NUM_REQ-1:0]      req_d_denied,
    output logic [32*NUM_REQ-1:0]   req_d_data,
    output logic [NUM_REQ-1:0]      req_d_corrupt,
    output logic [NUM_REQ-1:0]      req_d_valid,
    input  logic [NUM_REQ-1:0]      req_d_ready,
    output logic [2:0]              mem_a_opcode,
    output logic [2:0]              mem_a_param,
    output logic [3:0]              mem_a_size,
    output logic [31:0]             mem_a_address,
    output logic [3:0]              mem_a_mask,
    output logic [31:0]             mem_a_data,
    output logic                    mem_a_corrupt,
    output logic                    mem_a_valid,
    input  logic                    mem_a_ready,
    input  logic [2:0]              mem_d_opcode,
    input  logic [1:0]              mem_d_param,
    input  logic [3:0]              mem_d_size,
    input  logic                    mem_d_denied,
    input  logic [31:0]             mem_d_data,
    input  logic                    mem_d_corrupt,
    input  logic                    mem_d_valid,
    output logic                    mem_d_ready,
    output logic                    err_o
);

    typedef enum logic {
        A_IDLE,
        A_BURST
    } a_state_t;

    a_state_t          a_state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  lock_idx;
    logic [IDX_W-1:0]  rr_idx;
    logic [IDX_W-1:0]  grant;
    logic [BEAT_W-1:0] a_cnt;
    logic [BEAT_W-1:0] d_cnt;
    logic [BEAT_W-1:0] a_beats;
    logic [NUM_REQ-1:0] rot;
    logic              locked;
    logic              a_open;
    logic              a_fire;
    logic              a_first;
    logic              push;
    logic              pop;
    logic              d_fire;
    logic              fifo_full;
    logic              fifo_empty;
    logic              err_set;
    track_entry_t      push_data;
    track_entry_t      head;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // first valid requester at or after rr_ptr, found on a rotated view
    always_comb begin
        logic           found;
        logic [IDX_W:0] sum;
        found  = 1'b0;
        sum    = '0;
        rr_idx = rr_ptr;
        rot    = NUM_REQ'({req_a_valid, req_a_valid} >> rr_ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found  = 1'b1;
                sum    = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                rr_idx = (sum >= (IDX_W+1)'(NUM_REQ))
                       ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                       : IDX_W'(sum);
            end
        end
    end

    assign locked = (a_state == A_BURST);
    assign grant  = locked ? lock_idx : rr_idx;
    // A locked burst already owns its FIFO slot; a same-cycle pop frees one.
    assign a_open = !rst && (locked || !fifo_full || pop);

    // steer the granted requester onto the memory A channel
    always_comb begin
        mem_a_opcode  = '0;
        mem_a_param   = '0;
        mem_a_size    = '0;
        mem_a_address = '0;
        mem_a_mask    = '0;
        mem_a_data    = '0;
        mem_a_corrupt = 1'b0;
        mem_a_valid   = 1'b0;
        req_a_ready   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == IDX_W'(k)) begin
                mem_a_opcode   = req_a_opcode[k*3 +: 3];
                mem_a_param    = req_a_param[k*3 +: 3];
                mem_a_size     = req_a_size[k*4 +: 4];
                mem_a_address  = req_a_address[k*32 +: 32];
                mem_a_mask     = req_a_mask[k*4 +: 4];
                mem_a_data     = req_a_data[k*32 +: 32];
                mem_a_corrupt  = req_a_corrupt[k];
                mem_a_valid    = a_open && req_a_valid[k];
                req_a_ready[k] = a_open && mem_a_ready;
            end
        end
    end

    assign a_fire    = mem_a_valid && mem_a_ready;
    assign a_first   = a_fire && !locked;
    assign a_beats   = beats_from_size(mem_a_opcode, mem_a_size, 1'b1);
    assign push      = a_first;
    assign push_data = '{idx: grant,
                         beats: beats_from_size(mem_a_opcode, mem_a_size, 1'b0)};

    // route D to the head requester; an empty FIFO swallows stray beats
    always_comb begin
        req_d_valid = '0;
        mem_d_ready = !rst && fifo_empty;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!fifo_empty && head.idx == IDX_W'(k)) begin
                req_d_valid[k] = !rst && mem_d_valid;
                mem_d_ready    = !rst && req_d_ready[k];
            end
        end
    end

    assign req_d_opcode  = {NUM_REQ{mem_d_opcode}};
    assign req_d_param   = {NUM_REQ{mem_d_param}};
    assign req_d_size    = {NUM_REQ{mem_d_size}};
    assign req_d_denied  = {NUM_REQ{mem_d_denied}};
    assign req_d_data    = {NUM_REQ{mem_d_data}};
    assign req_d_corrupt = {NUM_REQ{mem_d_corrupt}};

    assign d_fire  = mem_d_valid && mem_d_ready && !fifo_empty;
    assign pop     = d_fire && ((d_cnt + 1'b1) == head.beats);
    assign err_set = (mem_d_valid && fifo_empty)
                   || (a_first && size_illegal(mem_a_size));

    frag_mem_track_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // burst lock FSM and round-robin pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            a_state  <= A_IDLE;
            lock_idx <= '0;
            a_cnt    <= '0;
            rr_ptr   <= '0;
        end else if (a_fire) begin
            case (a_state)
                A_IDLE: begin
                    if (a_beats > BEAT_W'(1)) begin
                        a_state  <= A_BURST;
                        lock_idx <= grant;
                        a_cnt    <= a_beats - 1'b1;
                    end else begin
                        rr_ptr <= next_idx(grant);
                    end
                end
                A_BURST: begin
                    if (a_cnt == BEAT_W'(1)) begin
                        a_state <= A_IDLE;
                        a_cnt   <= '0;
                        rr_ptr  <= next_idx(lock_idx);
                    end else begin
                        a_cnt <= a_cnt - 1'b1;
                    end
                end
                default: a_state <= A_IDLE;
            endcase
        end
    end

    // D beat counter and sticky protocol error
    always_ff @(posedge clk) begin
        if (rst) begin
            d_cnt <= '0;
            err_o <= 1'b0;
        end else begin
            if (d_fire) begin
                d_cnt <= pop ? '0 : d_cnt + 1'b1;
            end
            if (err_set) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frag_mem_arbiter.sv
// Scoreboard bench for frag_mem_arbiter.
// Expected A beats and D deliveries are queued as stimulus is driven.
module tb_frag_mem_arbiter;
    import frag_mem_pkg::*;

    localparam int N = 4;
    localparam int DEPTH = 4;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3*N-1:0]  req_a_opcode;
    logic [3*N-1:0]  req_a_param;
    logic [4*N-1:0]  req_a_size;
    logic [32*N-1:0] req_a_address;
    logic [4*N-1:0]  req_a_mask;
    logic [32*N-1:0] req_a_data;
    logic [N-1:0]    req_a_corrupt;
    logic [N-1:0]    req_a_valid;
    logic [N-1:0]    req_a_ready;
    logic [3*N-1:0]  req_d_opcode;
    logic [2*N-1:0]  req_d_param;
    logic [4*N-1:0]  req_d_size;
    logic [N-1:0]    req_d_denied;
    logic [32*N-1:0] req_d_data;
    logic [N-1:0]    req_d_corrupt;
    logic [N-1:0]    req_d_valid;
    logic [N-1:0]    req_d_ready;
    logic [2:0]      mem_a_opcode;
    logic [2:0]      mem_a_param;
    logic [3:0]      mem_a_size;
    logic [31:0]     mem_a_address;
    logic [3:0]      mem_a_mask;
    logic [31:0]     mem_a_data;
    logic            mem_a_corrupt;
    logic            mem_a_valid;
    logic            mem_a_ready;
    logic [2:0]      mem_d_opcode;
    logic [1:0]      mem_d_param;
    logic [3:0]      mem_d_size;
    logic            mem_d_denied;
    logic [31:0]     mem_d_data;
    logic            mem_d_corrupt;
    logic            mem_d_valid;
    logic            mem_d_ready;
    logic            err_o;

    frag_mem_arbiter #(.NUM_REQ(N), .OUTSTANDING(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_a_opcode(req_a_opcode), .req_a_param(req_a_param),
        .req_a_size(req_a_size), .req_a_address(req_a_address),
        .req_a_mask(req_a_mask), .req_a_data(req_a_data),
        .req_a_corrupt(req_a_corrupt), .req_a_valid(req_a_valid),
        .req_a_ready(req_a_ready),
        .req_d_opcode(req_d_opcode), .req_d_param(req_d_param),
        .req_d_size(req_d_size), .req_d_denied(req_d_denied),
        .req_d_data(req_d_data), .req_d_corrupt(req_d_corrupt),
        .req_d_valid(req_d_valid), .req_d_ready(req_d_ready),
        .mem_a_opcode(mem_a_opcode), .mem_a_param(mem_a_param),
        .mem_a_size(mem_a_size), .mem_a_address(mem_a_address),
        .mem_a_mask(mem_a_mask), .mem_a_data(mem_a_data),
        .mem_a_corrupt(mem_a_corrupt), .mem_a_valid(mem_a_valid),
        .mem_a_ready(mem_a_ready),
        .mem_d_opcode(mem_d_opcode), .mem_d_param(mem_d_param),
        .mem_d_size(mem_d_size), .mem_d_denied(mem_d_denied),
        .mem_d_data(mem_d_data), .mem_d_corrupt(mem_d_corrupt),
        .mem_d_valid(mem_d_valid), .mem_d_ready(mem_d_ready),
        .err_o(err_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } a_exp_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } d_exp_t;

    a_exp_t exp_a[$];
    d_exp_t exp_d[$];
    int d_count[N];
    int only_idx = -1;
    logic [N-1:0] a_hs = '0;
    logic m_d_hs = 1'b0;
    a_exp_t ea;
    d_exp_t ed;
    logic [N-1:0] msk;

    // sample one time unit before each rising edge
    always @(negedge clk) begin
        #4;
        for (int i = 0; i < N; i++) a_hs[i] = req_a_valid[i] && req_a_ready[i];
        m_d_hs = mem_d_valid && mem_d_ready;
        if (mem_a_valid && mem_a_ready) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected", mem_a_address, 32'hFFFF_FFFF);
            end else begin
                ea = exp_a.pop_front();
                check("a_addr", mem_a_address, ea.addr);
                check("a_data", mem_a_data, ea.data);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_d_valid[i] && req_d_ready[i]) begin
                d_count[i]++;
                if (exp_d.size() == 0) begin
                    check("d_unexpected", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    ed = exp_d.pop_front();
                    check("d_idx", 32'(i), 32'(ed.idx));
                    check("d_data", req_d_data[i*32 +: 32], ed.data);
                end
            end
        end
        if (only_idx >= 0) begin
            msk = '1;
            msk[only_idx] = 1'b0;
            check("d_other_valid", 32'(req_d_valid & msk), 32'd0);
        end
    end

    task automatic exp_a_push(input logic [31:0] addr, input int nb);
        for (int b = 0; b < nb; b++) exp_a.push_back('{addr, addr + b});
    endtask

    // drive nb A beats from requester i; call at a falling edge
    task automatic a_xfer(input int i, input logic [2:0] opc,
                          input logic [3:0] sz, input logic [31:0] addr,
                          input int nb);
        int t;
        for (int b = 0; b < nb; b++) begin
            req_a_opcode[i*3 +: 3]    = opc;
            req_a_size[i*4 +: 4]      = sz;
            req_a_address[i*32 +: 32] = addr;
            req_a_data[i*32 +: 32]    = addr + b;
            req_a_mask[i*4 +: 4]      = 4'hF;
            req_a_valid[i]            = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!a_hs[i] && t < TMO);
            if (!a_hs[i]) begin
                check("a_timeout", 32'(a_hs[i]), 32'd1);
                break;
            end
        end
        req_a_valid[i] = 1'b0;
    endtask

    // drive nb D beats destined for requester idx; call at a falling edge
    task automatic d_send(input int idx, input logic [2:0] opc,
                          input logic [31:0] data, input int nb,
                          input bit gap);
        int t;
        for (int b = 0; b < nb; b++) begin
            mem_d_opcode = opc;
            mem_d_data   = data + b;
            mem_d_valid  = 1'b1;
            exp_d.push_back('{idx, data + b});
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!m_d_hs && t < TMO);
            if (!m_d_hs) begin
                check("d_timeout", 32'(m_d_hs), 32'd1);
                break;
            end
            if (gap && b < nb - 1) begin
                mem_d_valid = 1'b0;
                @(negedge clk);
            end
        end
        mem_d_valid = 1'b0;
    endtask

    bit stall_on;
    int d_base;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_a_opcode = '0; req_a_param = '0; req_a_size = '0;
        req_a_address = '0; req_a_mask = '0; req_a_data = '0;
        req_a_corrupt = '0; req_a_valid = 4'b0101;
        req_d_ready = '1; mem_a_ready = 1'b1;
        mem_d_opcode = '0; mem_d_param = '0; mem_d_size = 4'd2;
        mem_d_denied = 1'b0; mem_d_data = '0; mem_d_corrupt = 1'b0;
        mem_d_valid = 1'b1;
        for (int i = 0; i < N; i++) d_count[i] = 0;

        // reset cycle: every ready/valid output held low
        @(negedge clk);
        #4;
        check("rst_a_ready", 32'(req_a_ready), 32'd0);
        check("rst_mem_a_valid", 32'(mem_a_valid), 32'd0);
        check("rst_d_valid", 32'(req_d_valid), 32'd0);
        check("rst_mem_d_ready", 32'(mem_d_ready), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_a_valid = '0;
        mem_d_valid = 1'b0;
        #4;
        check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        check("rst_fifo_empty", 32'(dut.fifo_empty), 32'd1);
        @(negedge clk);

        // two Gets contend at rr_ptr=0: req0 then req2
        exp_a_push(32'h0000_0010, 1);
        exp_a_push(32'h0000_0210, 1);
        fork
            a_xfer(0, TL_A_GET, 4'd2, 32'h0000_0010, 1);
            a_xfer(2, TL_A_GET, 4'd2, 32'h0000_0210, 1);
        join
        check("t1_rr_ptr", 32'(dut.rr_ptr), 32'd3);
        d_send(0, TL_D_ACK_DATA, 32'hD000_0000, 1, 1'b0);
        d_send(2, TL_D_ACK_DATA, 32'hD200_0000, 1, 1'b0);
        check("t1_d0_count", 32'(d_count[0]), 32'd1);
        check("t1_d2_count", 32'(d_count[2]), 32'd1);
        check("t1_fifo_empty", 32'(dut.fifo_empty), 32'd1);

        // 4-beat PutFull from req1 holds the grant against req3
        exp_a_push(32'h0000_0110, 4);
        exp_a_push(32'h0000_0310, 1);
        fork
            a_xfer(1, TL_A_PUT_FULL, 4'd4, 32'h0000_0110, 4);
            begin
                @(negedge clk);
                a_xfer(3, TL_A_GET, 4'd2, 32'h0000_0310, 1);
            end
        join
        check("t2_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        d_send(1, TL_D_ACK, 32'hA100_0000, 1, 1'b0);
        d_send(3, TL_D_ACK_DATA, 32'hD300_0000, 1, 1'b0);
        check("t2_d1_count", 32'(d_count[1]), 32'd1);
        check("t2_d_opcode", 32'(req_d_opcode[2:0]), 32'(TL_D_ACK_DATA));
        check("t2_fifo_empty", 32'(dut.fifo_empty), 32'd1);

        // fill the tracking FIFO, then push and pop in the same cycle
        for (int k = 0; k < DEPTH; k++) begin
            exp_a_push(32'h0000_0020 + k, 1);
            a_xfer(0, TL_A_GET, 4'd2, 32'h0000_0020 + k, 1);
        end
        check("t3_full", 32'(dut.fifo_full), 32'd1);
        exp_a_push(32'h0000_0120, 1);
        fork
            a_xfer(1, TL_A_GET, 4'd2, 32'h0000_0120, 1);
        join_none
        #4;
        check("t3_full_ready", 32'(req_a_ready[1]), 32'd0);
        check("t3_full_mvalid", 32'(mem_a_valid), 32'd0);
        @(negedge clk);
        #4;
        check("t3_full_ready2", 32'(req_a_ready[1]), 32'd0);
        @(negedge clk);
        mem_d_opcode = TL_D_ACK_DATA;
        mem_d_data = 32'hE000_0000;
        mem_d_valid = 1'b1;
        exp_d.push_back('{0, 32'hE000_0000});
        #4;
        check("t3_pop_ready", 32'(req_a_ready[1]), 32'd1);
        check("t3_pop_d_ready", 32'(mem_d_ready), 32'd1);
        @(negedge clk);
        mem_d_valid = 1'b0;
        check("t3_still_full", 32'(dut.fifo_full), 32'd1);
        for (int k = 1; k < DEPTH; k++) begin
            d_send(0, TL_D_ACK_DATA, 32'hE000_0000 + k, 1, 1'b0);
        end
        d_send(1, TL_D_ACK_DATA, 32'hE100_0000, 1, 1'b0);
        check("t3_fifo_empty", 32'(dut.fifo_empty), 32'd1);

        // 4-beat Get response with gaps and requester back-pressure
        exp_a_push(32'h0000_0230, 1);
        a_xfer(2, TL_A_GET, 4'd4, 32'h0000_0230, 1);
        d_base = d_count[2];
        only_idx = 2;
        stall_on = 1'b1;
        fork
            begin
                d_send(2, TL_D_ACK_DATA, 32'hF000_0000, 4, 1'b1);
                stall_on = 1'b0;
            end
            begin
                while (stall_on) begin
                    req_d_ready[2] = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                req_d_ready[2] = 1'b1;
            end
        join
        only_idx = -1;
        check("t4_beats", 32'(d_count[2] - d_base), 32'd4);
        check("t4_fifo_empty", 32'(dut.fifo_empty), 32'd1);
        check("t4_err", 32'(err_o), 32'd0);

        // stray D beat with nothing outstanding
        mem_d_valid = 1'b1;
        mem_d_data = 32'hBAD0_0000;
        #4;
        check("t5_d_ready", 32'(mem_d_ready), 32'd1);
        check("t5_d_valid", 32'(req_d_valid), 32'd0);
        @(negedge clk);
        mem_d_valid = 1'b0;
        #4;
        check("t5_err", 32'(err_o), 32'd1);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", 32'(err_o), 32'd1);

        // reset after 2 of 4 burst beats abandons everything
        exp_a_push(32'h0000_0140, 2);
        a_xfer(1, TL_A_PUT_FULL, 4'd4, 32'h0000_0140, 2);
        rst = 1'b1;
        req_a_opcode[9 +: 3] = TL_A_GET;
        req_a_size[12 +: 4] = 4'd2;
        req_a_valid[3] = 1'b1;
        mem_d_valid = 1'b1;
        #4;
        check("t6_a_ready", 32'(req_a_ready), 32'd0);
        check("t6_mem_a_valid", 32'(mem_a_valid), 32'd0);
        check("t6_d_valid", 32'(req_d_valid), 32'd0);
        check("t6_mem_d_ready", 32'(mem_d_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_a_valid = '0;
        mem_d_valid = 1'b0;
        check("t6_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        check("t6_fifo_empty", 32'(dut.fifo_empty), 32'd1);
        check("t6_err_clear", 32'(err_o), 32'd0);
        exp_a_push(32'h0000_0150, 1);
        a_xfer(0, TL_A_GET, 4'd2, 32'h0000_0150, 1);
        check("t6_rr_after", 32'(dut.rr_ptr), 32'd1);
        d_send(0, TL_D_ACK_DATA, 32'h5150_0000, 1, 1'b0);
        check("t6_fifo_drained", 32'(dut.fifo_empty), 32'd1);

        // illegal size flags an error and tracks a single D beat
        exp_a_push(32'h0000_0360, 1);
        a_xfer(3, TL_A_GET, 4'd5, 32'h0000_0360, 1);
        check("t7_err", 32'(err_o), 32'd1);
        check("t7_fifo_busy", 32'(dut.fifo_empty), 32'd0);
        d_send(3, TL_D_ACK_DATA, 32'h7360_0000, 1, 1'b0);
        check("t7_fifo_empty", 32'(dut.fifo_empty), 32'd1);

        repeat (2) @(negedge clk);
        check("exp_a_left", 32'(exp_a.size()), 32'd0);
        check("exp_d_left", 32'(exp_d.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frag_mem_arbiter.md
Name: frag_mem_arbiter

Overview:
- Shares one downstream TileLink-UH master port (32-bit data) between NUM_REQ upstream TL-UH masters, e.g. the texture/data-cache ports of several fragment cores.
- Grants the A channel round-robin and holds the grant for the whole multi-beat Put burst.
- Records each accepted transaction in an in-order tracking FIFO; D-channel responses are steered back to the requester at the FIFO head.
- Sits between the fragment cores and the system memory interconnect.

Parameters:
- NUM_REQ, 4: number of upstream requesters (2..8).
- OUTSTANDING, 4: tracking FIFO depth, which is the maximum number of in-flight transactions (power of two).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_a_opcode  in  3*NUM_REQ  per-requester A opcode
- req_a_param  in  3*NUM_REQ  A param
- req_a_size  in  4*NUM_REQ  log2 bytes
- req_a_address  in  32*NUM_REQ  address
- req_a_mask  in  4*NUM_REQ  byte mask
- req_a_data  in  32*NUM_REQ  write data
- req_a_corrupt  in  NUM_REQ  corrupt
- req_a_valid  in  NUM_REQ  A valid
- req_a_ready  out  NUM_REQ  A ready
- req_d_opcode  out  3*NUM_REQ  D opcode (broadcast)
- req_d_param  out  2*NUM_REQ  D param (broadcast)
- req_d_size  out  4*NUM_REQ  D size (broadcast)
- req_d_denied  out  NUM_REQ  denied (broadcast)
- req_d_data  out  32*NUM_REQ  D data (broadcast)
- req_d_corrupt  out  NUM_REQ  corrupt (broadcast)
- req_d_valid  out  NUM_REQ  D valid, only for the FIFO-head requester
- req_d_ready  in  NUM_REQ  D ready
- mem_a_opcode, mem_a_param, mem_a_size, mem_a_address, mem_a_mask, mem_a_data, mem_a_corrupt, mem_a_valid  out  3/3/4/32/4/32/1/1  downstream A channel
- mem_a_ready  in  1  downstream A ready
- mem_d_opcode, mem_d_param, mem_d_size, mem_d_denied, mem_d_data, mem_d_corrupt, mem_d_valid  in  3/2/4/1/32/1/1  downstream D channel
- mem_d_ready  out  1  downstream D ready
- err_o  out  1  sticky protocol error

Behaviour:
- Reset:
  - rr_ptr=0, grant idle, burst lock clear, FIFO empty, err_o=0.
  - All ready and valid outputs are 0 in the reset cycle.
  - Reset mid-burst or mid-response abandons all state; there is no drain.
- Opcodes:
  - A: Get=4, PutFullData=0, PutPartialData=1.
  - D: AccessAckData=1, AccessAck=0.
- Beat counts (size field s):
  - A beats = 2^(s-2) for Put with s>2, else 1.
  - D beats = 2^(s-2) for Get with s>2, else 1.
  - s>4 is illegal: set err_o and treat as 1 beat.
- Arbitration (combinational select, registered state):
  - When unlocked and FIFO not full, grant goes to the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - mem_a_* = granted requester's A fields; mem_a_valid = its a_valid.
  - req_a_ready[g] = mem_a_ready for the granted g; all others are 0.
  - Zero added latency; the A path is purely combinational.
- Transaction start:
  - On the first A beat handshake, push {req_idx, d_beats} into the FIFO.
  - If the transaction has more than one A beat, set lock and load the A beat counter.
- Burst lock:
  - While locked, the grant is frozen regardless of other requests and FIFO state.
  - The counter decrements per handshake; unlock after the last beat.
- rr_ptr update:
  - After the last A beat of a transaction, rr_ptr = granted index + 1 (mod NUM_REQ).
  - rr_ptr is unchanged while idle.
- FIFO full:
  - With no lock and a full FIFO, mem_a_valid=0 and every req_a_ready=0.
  - A locked burst continues; its entry was already pushed.
- D routing:
  - D fields are broadcast to all requesters.
  - req_d_valid[head.idx] = mem_d_valid; mem_d_ready = req_d_ready[head.idx].
  - The D beat counter counts handshakes; pop at head.d_beats.
- Simultaneous push and pop is allowed at any occupancy, including full: the pop frees the slot in the same cycle.
- D with an empty FIFO:
  - Set err_o, hold mem_d_ready=1 to drain the beat, assert no req_d_valid.
- err_o stays high until rst.

Decomposition:
- Package frag_mem_pkg holds:
  - TL opcode localparams.
  - Function beats_from_size(opcode, size, is_a).
  - Typedef track_entry_t {idx: $clog2(NUM_REQ) bits, beats: 3 bits}.
- Sub-module frag_mem_track_fifo: synchronous FIFO with push, pop, full, empty and head; supports simultaneous push and pop.
- Round-robin select stays inline.

Test Plan:
- Req0 and req2 both send a Get (s=2) at rr_ptr=0 → req0 is granted first, req2 next cycle; rr_ptr ends at 3; D beats return to req0 then req2 in order.
- Req1 sends PutFull s=4 (4 beats) while req3 sends a Get → req1 keeps the grant for 4 handshakes, req3 is granted on the following beat; req1 receives a single AccessAck.
- OUTSTANDING=4 Gets issued with mem_d_valid held 0 → the 5th request sees req_a_ready=0; one D pop in the same cycle as a new A push keeps occupancy at 4.
- Get s=4 from req2 with mem_d_valid toggling and req_d_ready stalling → exactly 4 beats delivered to req2, other req_d_valid stay 0, then the FIFO pops.
- mem_d_valid=1 with the FIFO empty → err_o=1 next cycle and stays 1; mem_d_ready=1; no req_d_valid.
- rst asserted mid-burst (2 of 4 beats done) → next cycle all outputs 0, FIFO empty, rr_ptr=0; a fresh Get completes normally.
